pipe_wb_trace: RTL and testbench
================================

// Module: pipe_wb_trace
// PURPOSE
//  Commit-trace buffer downstream of the WB stage of the pipelined computer.
//  - Captures every register-file write (rn, value) into a FIFO, tagged with a sequence number.
//  - Presents records on a valid/ready stream for a debug sink (UART bridge, on-chip logger).
//  - Never stalls the pipeline. Records that find the FIFO full are dropped and counted.
// PARAMETERS
//  DEPTH   8    FIFO entries; power of two, >= 2
//  AW      3    log2(DEPTH); pointer width
//  SEQW    16   sequence-number width
// PORTS
//  clock      in   1     system clock; all state updates on the rising edge
//  reset      in   1     synchronous, active-high reset
//  en         in   1     capture enable; 0 ignores commits (seq does not advance)
//  wwreg      in   1     WB-stage register-write enable
//  wrn        in   5     WB-stage destination register number
//  wdi        in   32    WB-stage write data
//  tr_valid   out  1     head record available
//  tr_ready   in   1     sink accepts head record this cycle
//  tr_seq     out  SEQW  head record sequence number
//  tr_rn      out  5     head record register number
//  tr_data    out  32    head record data
//  count      out  AW+1  occupancy, 0..DEPTH
//  full       out  1     count == DEPTH
//  drop_cnt   out  8     dropped commits, saturating at 255
// BEHAVIOUR
//  Clock and reset
//  - One clock. Reset is synchronous and active-high.
//  - Reset mid-operation flushes the FIFO.
//  - Reset values: pointers 0, count 0, tr_valid 0, full 0, seq 0, drop_cnt 0.
//  - tr_seq, tr_rn and tr_data read 0 while empty after reset.
//  Commit and push
//  - commit = en & wwreg & (wrn != 0). r0 writes are never traced.
//  - Each commit consumes one seq value; seq then increments mod 2^SEQW, whether or not the record is stored.
//  - Dropped commits therefore show as gaps in tr_seq.
//  - push = commit & (!full | pop).
//  - When full, a commit is still stored if a pop happens in the same cycle.
//  - drop = commit & full & !pop. A drop increments drop_cnt, saturating at 255.
//  Pop and output
//  - pop = tr_valid & tr_ready. tr_ready while tr_valid=0 has no effect.
//  - First-word-fall-through: tr_valid = (count != 0), driven from registered state.
//  - The head record is stable while tr_valid=1 & tr_ready=0.
//  - Latency: a commit at edge N is visible on tr_* after edge N (no cycle of bubble when empty).
//  - The FIFO is never bypassed combinationally: a commit sampled at an edge is not on tr_* before that edge.
//  Count and pointers
//  - push & pop in the same cycle: count is unchanged; both pointers advance.
//  - Pointers wrap modulo DEPTH.
//  - count and full are registered, consistent with the pointers every cycle.
//  Ordering and data path
//  - Records leave in strict commit order.
//  - Purely sequential capture; no combinational path from wwreg/wrn/wdi to any output.
// TESTING
//  1. Reset, then wwreg=1, wrn=5, wdi=0xDEADBEEF for 1 cycle
//     -> next cycle: tr_valid=1, tr_seq=0, tr_rn=5, tr_data=0xDEADBEEF, count=1.
//  2. wrn=0 with wwreg=1, and wwreg=1 with en=0
//     -> no record, count stays 0, next real commit gets seq=0.
//  3. tr_ready=0, 10 commits of wdi=i (i=0..9)
//     -> count=8, full=1, drop_cnt=2.
//     Then drain -> seq 0..7 in order, data 0..7.
//  4. Full FIFO, commit plus tr_ready=1 in the same cycle
//     -> count stays 8, drop_cnt unchanged, new record is at the tail.
//  5. Continuous commits with tr_ready=1 for 300 cycles
//     -> count<=1 throughout, no drops, seq wraps correctly past 0xFFFF when preset.
//     Separately, 300 drops -> drop_cnt=255.
//  6. Reset asserted with count=5
//     -> next cycle count=0, tr_valid=0, drop_cnt=0.
//     Next commit gets seq=0.

Source files
------------

// File: rtl/pipe_wb_trace.sv
// Commit-trace buffer behind the WB stage: every non-r0 register write is tagged
// with a sequence number and queued for a valid/ready debug sink; overflow drops.
module pipe_wb_trace #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int SEQW  = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic            wwreg,
    input  logic [4:0]      wrn,
    input  logic [31:0]     wdi,
    output logic            tr_valid,
    input  logic            tr_ready,
    output logic [SEQW-1:0] tr_seq,
    output logic [4:0]      tr_rn,
    output logic [31:0]     tr_data,
    output logic [AW:0]     count,
    output logic            full,
    output logic [7:0]      drop_cnt
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [SEQW-1:0] SEQ_ONE = SEQW'(1);

    logic [SEQW-1:0] mem_seq_r  [DEPTH];
    logic [4:0]      mem_rn_r   [DEPTH];
    logic [31:0]     mem_data_r [DEPTH];

    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic [AW:0]     count_nxt_s;
    logic            full_r;
    logic            valid_r;
    logic [SEQW-1:0] seq_r;
    logic [7:0]      drop_r;

    logic            commit_s;
    logic            pop_s;
    logic            push_s;
    logic            drop_s;

    // Handshake decode: a full FIFO still accepts a commit when the head leaves in the same cycle
    always_comb begin
        commit_s = en & wwreg & (wrn != 5'd0);
        pop_s    = valid_r & tr_ready;
        push_s   = commit_s & (~full_r | pop_s);
        drop_s   = commit_s & full_r & ~pop_s;
    end

    // Next occupancy from the push/pop pair
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy and status registers; flags derived from next count so they never lag
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == FULL_CNT);
            valid_r <= (count_nxt_s != '0);
        end
    end

    // Sequence and saturating drop counters; seq advances on every commit, stored or not
    always_ff @(posedge clock) begin
        if (reset) begin
            seq_r  <= '0;
            drop_r <= 8'd0;
        end else begin
            if (commit_s) seq_r <= seq_r + SEQ_ONE;
            if (drop_s && (drop_r != 8'hFF)) drop_r <= drop_r + 8'd1;
        end
    end

    // Record storage; contents are don't-care until written since the head is masked when empty
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_seq_r[wr_ptr_r]  <= seq_r;
            mem_rn_r[wr_ptr_r]   <= wrn;
            mem_data_r[wr_ptr_r] <= wdi;
        end
    end

    // First-word-fall-through head, forced to zero while empty
    always_comb begin
        if (valid_r) begin
            tr_seq  = mem_seq_r[rd_ptr_r];
            tr_rn   = mem_rn_r[rd_ptr_r];
            tr_data = mem_data_r[rd_ptr_r];
        end else begin
            tr_seq  = '0;
            tr_rn   = 5'd0;
            tr_data = 32'd0;
        end
    end

    assign tr_valid = valid_r;
    assign count    = count_r;
    assign full     = full_r;
    assign drop_cnt = drop_r;

endmodule

// File: tb/tb_pipe_wb_trace.sv
// Randomised scoreboard bench for pipe_wb_trace; a second narrow-seq instance with
// an always-ready sink exercises sequence wrap-around.
module tb_pipe_wb_trace;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        wwreg = 1'b0;
    logic [4:0]  wrn = 5'd0;
    logic [31:0] wdi = 32'd0;
    logic        tr_ready = 1'b0;

    logic        tr_valid;
    logic [15:0] tr_seq;
    logic [4:0]  tr_rn;
    logic [31:0] tr_data;
    logic [3:0]  count;
    logic        full;
    logic [7:0]  drop_cnt;

    logic        w_valid;
    logic [3:0]  w_seq;
    logic [4:0]  w_rn;
    logic [31:0] w_data;
    logic [3:0]  w_count;
    logic        w_full;
    logic [7:0]  w_drop;

    always #5 clock = ~clock;

    pipe_wb_trace dut (
        .clock(clock), .reset(reset), .en(en), .wwreg(wwreg), .wrn(wrn), .wdi(wdi),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_seq(tr_seq), .tr_rn(tr_rn),
        .tr_data(tr_data), .count(count), .full(full), .drop_cnt(drop_cnt)
    );

    pipe_wb_trace #(.DEPTH(8), .AW(3), .SEQW(4)) dut_w (
        .clock(clock), .reset(reset), .en(en), .wwreg(wwreg), .wrn(wrn), .wdi(wdi),
        .tr_valid(w_valid), .tr_ready(1'b1), .tr_seq(w_seq), .tr_rn(w_rn),
        .tr_data(w_data), .count(w_count), .full(w_full), .drop_cnt(w_drop)
    );

    typedef struct {
        int          seq;
        logic [4:0]  rn;
        logic [31:0] data;
    } rec_t;

    rec_t exp_q[$];
    rec_t wexp_q[$];
    rec_t mr;
    rec_t wr;

    int checks = 0;
    int errors = 0;
    int occ    = 0;
    int drop_m = 0;
    int seq_m  = 0;
    int wseq_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock of stimulus; the model decides the fate of the commit before the edge
    task automatic step(input bit c_en, input bit c_we, input logic [4:0] rn,
                        input logic [31:0] d, input bit rdy);
        bit   pop;
        bit   commit;
        rec_t r;
        en = c_en; wwreg = c_we; wrn = rn; wdi = d; tr_ready = rdy;
        pop    = (occ != 0) && rdy;
        commit = c_en && c_we && (rn != 5'd0);
        if (pop) occ--;
        if (commit) begin
            r.seq = seq_m; r.rn = rn; r.data = d;
            if (occ < 8) begin
                exp_q.push_back(r);
                occ++;
            end else if (drop_m < 255) begin
                drop_m++;
            end
            seq_m = (seq_m + 1) % 65536;
            r.seq = wseq_m;
            wexp_q.push_back(r);
            wseq_m = (wseq_m + 1) % 16;
        end
        @(posedge clock); #1;
        chk("count", 64'(count), 64'(occ));
        chk("full", 64'(full), 64'(occ == 8));
        chk("tr_valid", 64'(tr_valid), 64'(occ != 0));
        chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
    endtask

    task automatic do_reset();
        reset = 1'b1; tr_ready = 1'b0; en = 1'b0; wwreg = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        occ = 0; drop_m = 0; seq_m = 0; wseq_m = 0;
        exp_q.delete();
        wexp_q.delete();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(tr_valid), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_head", {11'd0, tr_rn, tr_seq, tr_data}, 64'd0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    endtask

    // Scoreboard monitor: compares the head on every accepted transfer, between edges
    always @(negedge clock) begin
        if (!reset && tr_valid && tr_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_record", 64'(tr_seq), 64'hFFFF_FFFF);
            end else begin
                mr = exp_q.pop_front();
                chk("sb_seq", 64'(tr_seq), 64'(mr.seq));
                chk("sb_rn", 64'(tr_rn), 64'(mr.rn));
                chk("sb_data", 64'(tr_data), 64'(mr.data));
            end
        end
        if (!reset && w_valid) begin
            if (wexp_q.size() == 0) begin
                chk("w_unexpected_record", 64'(w_seq), 64'hFFFF_FFFF);
            end else begin
                wr = wexp_q.pop_front();
                chk("w_seq", 64'(w_seq), 64'(wr.seq));
                chk("w_data", 64'(w_data), 64'(wr.data));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single commit lands on the head after one edge
        do_reset();
        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        chk("t1_seq", 64'(tr_seq), 64'd0);
        chk("t1_rn", 64'(tr_rn), 64'd5);
        chk("t1_data", 64'(tr_data), 64'hDEADBEEF);
        drain(1);

        // r0 writes and disabled capture leave no trace and consume no seq
        do_reset();
        step(1'b1, 1'b1, 5'd0, 32'h1111_1111, 1'b0);
        step(1'b0, 1'b1, 5'd7, 32'h2222_2222, 1'b0);
        step(1'b1, 1'b1, 5'd9, 32'h3333_3333, 1'b0);
        chk("t2_seq", 64'(tr_seq), 64'd0);
        drain(1);

        // Overflow with a stalled sink, then in-order drain
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 5'($urandom_range(31, 1)), 32'(i), 1'b0);
        chk("t3_count", 64'(count), 64'd8);
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_drop", 64'(drop_cnt), 64'd2);
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain_seq", 64'(tr_seq), 64'(i));
            chk("t3_drain_data", 64'(tr_data), 64'(i));
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        end

        // Full FIFO with simultaneous commit and pop keeps the record
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 5'd3, 32'h100 + 32'(i), 1'b0);
        step(1'b1, 1'b1, 5'd4, 32'hCAFE0004, 1'b1);
        chk("t4_count", 64'(count), 64'd8);
        chk("t4_drop", 64'(drop_cnt), 64'd2);
        drain(8);

        // Streaming with an always-ready sink; narrow instance wraps its seq many times
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 5'($urandom_range(31, 1)), $urandom, 1'b1);
            chk("t5_count_le1", 64'(count <= 4'd1), 64'd1);
        end
        drain(1);

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 308; i++) step(1'b1, 1'b1, 5'd12, 32'(i), 1'b0);
        chk("t5_drop_sat", 64'(drop_cnt), 64'd255);

        // Reset mid-operation flushes and restarts seq
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 5'd6, 32'(i), 1'b0);
        chk("t6_count5", 64'(count), 64'd5);
        do_reset();
        step(1'b1, 1'b1, 5'd8, 32'h8888_0000, 1'b0);
        chk("t6_seq", 64'(tr_seq), 64'd0);
        drain(1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step(($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0),
                 5'($urandom_range(31, 0)), $urandom, ($urandom_range(1, 0) == 1));
        drain(10);
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
